// File: rtl/des_in_loader.sv
// des_in_loader: byte-stream front end for the DES initial-permutation stage.
// Collects eight plaintext bytes into a 64-bit block, holds ip_start with a
// frozen block until the IP stage answers on ip_ready, then waits for ip_ready
// to drop before it accepts the next block.
//
// Optional feature: define DES_LOADER_TIMEOUT_EN to bound the wait in START to
// TIMEOUT_CYCLES cycles. On expiry err pulses and the block is abandoned.
// Without the macro START waits forever and err is tied low.
//
// Ports:
//   clk, rst_n         clock, asynchronous active-low reset
//   in_valid/in_data   plaintext byte stream, first byte of a block first
//   in_ready           high while a byte can be accepted (FILL only)
//   flush              discards a partially filled block (FILL only)
//   des_in[1:64]       assembled block, bit 1 = MSB of the first byte
//   ip_start/ip_ready  request/completion handshake with the IP stage
//   blk_done           one-cycle pulse per block handed off
//   blk_cnt            count of completed blocks, wraps at 16 bits
//   err                one-cycle pulse on START timeout
module des_in_loader #(
  parameter int unsigned TIMEOUT_CYCLES = 15
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  input  logic [7:0]  in_data,
  output logic        in_ready,
  input  logic        flush,
  output logic [1:64] des_in,
  output logic        ip_start,
  input  logic        ip_ready,
  output logic        blk_done,
  output logic [15:0] blk_cnt,
  output logic        err
);

  localparam int unsigned BYTE_W = 8;
  localparam int unsigned CNT_W  = 3;

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_FILL    = 2'd1,
    S_START   = 2'd2,
    S_RELEASE = 2'd3
  } state_e;

  state_e             state_q,    state_d;
  logic [CNT_W-1:0]   byte_cnt_q, byte_cnt_d;
  logic [1:64]        des_in_q,   des_in_d;
  logic               ip_start_q, ip_start_d;
  logic               blk_done_q, blk_done_d;
  logic [15:0]        blk_cnt_q,  blk_cnt_d;
  logic               err_q,      err_d;
  logic               to_expire_c;

`ifdef DES_LOADER_TIMEOUT_EN
  // Counter holds the number of START cycles already spent without ip_ready.
  localparam int unsigned TO_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  logic [TO_W-1:0] to_cnt_q, to_cnt_d;
  assign to_expire_c = (to_cnt_q == TO_W'(TIMEOUT_CYCLES - 1));
`else
  assign to_expire_c = 1'b0;
  // TIMEOUT_CYCLES only matters when the timeout is compiled in.
  if (TIMEOUT_CYCLES == 0) begin : g_timeout_unused
  end
`endif

  // Byte acceptance is decoded straight from the state register.
  assign in_ready = (state_q == S_FILL);
  assign des_in   = des_in_q;
  assign ip_start = ip_start_q;
  assign blk_done = blk_done_q;
  assign blk_cnt  = blk_cnt_q;
  assign err      = err_q;

  // Next-state and next-output logic.
  always_comb begin
    state_d    = state_q;
    byte_cnt_d = byte_cnt_q;
    des_in_d   = des_in_q;
    ip_start_d = ip_start_q;
    blk_done_d = 1'b0;
    blk_cnt_d  = blk_cnt_q;
    err_d      = 1'b0;
`ifdef DES_LOADER_TIMEOUT_EN
    to_cnt_d   = to_cnt_q;
`endif
    unique case (state_q)
      S_IDLE: state_d = S_FILL;
      S_FILL: begin
        // flush wins over a simultaneous byte, which is dropped
        if (flush) begin
          byte_cnt_d = '0;
        end else if (in_valid) begin
          for (int n = 0; n < 8; n++) begin
            if (byte_cnt_q == CNT_W'(n)) des_in_d[BYTE_W*n+1 +: BYTE_W] = in_data;
          end
          byte_cnt_d = byte_cnt_q + CNT_W'(1);
          if (byte_cnt_q == CNT_W'(7)) begin
            state_d    = S_START;
            ip_start_d = 1'b1;
`ifdef DES_LOADER_TIMEOUT_EN
            to_cnt_d   = '0;
`endif
          end
        end
      end
      S_START: begin
        // ip_ready on the expiry edge still counts as success
        if (ip_ready) begin
          ip_start_d = 1'b0;
          blk_done_d = 1'b1;
          blk_cnt_d  = blk_cnt_q + 16'd1;
          state_d    = S_RELEASE;
        end else if (to_expire_c) begin
          ip_start_d = 1'b0;
          err_d      = 1'b1;
          state_d    = S_RELEASE;
        end
`ifdef DES_LOADER_TIMEOUT_EN
        else begin
          to_cnt_d = to_cnt_q + TO_W'(1);
        end
`endif
      end
      S_RELEASE: begin
        // wait for the stage to drop ip_ready so it cannot complete the next block
        if (!ip_ready) state_d = S_FILL;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      byte_cnt_q <= '0;
      des_in_q   <= '0;
      ip_start_q <= 1'b0;
      blk_done_q <= 1'b0;
      blk_cnt_q  <= '0;
      err_q      <= 1'b0;
`ifdef DES_LOADER_TIMEOUT_EN
      to_cnt_q   <= '0;
`endif
    end else begin
      state_q    <= state_d;
      byte_cnt_q <= byte_cnt_d;
      des_in_q   <= des_in_d;
      ip_start_q <= ip_start_d;
      blk_done_q <= blk_done_d;
      blk_cnt_q  <= blk_cnt_d;
      err_q      <= err_d;
`ifdef DES_LOADER_TIMEOUT_EN
      to_cnt_q   <= to_cnt_d;
`endif
    end
  end

endmodule

// File: tb/tb_des_in_loader.sv
// Testbench for des_in_loader: table-driven blocks, randomized byte streams with
// flushes, timeout/no-timeout behaviour in START and reset while in START.
module tb_des_in_loader;
  localparam int unsigned TO = 4;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic [7:0]  in_data;
  logic        in_ready;
  logic        flush;
  logic [1:64] des_in;
  logic        ip_start;
  logic        ip_ready;
  logic        blk_done;
  logic [15:0] blk_cnt;
  logic        err;

  always #5 clk = ~clk;

  des_in_loader #(.TIMEOUT_CYCLES(TO)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_data(in_data),
    .in_ready(in_ready), .flush(flush), .des_in(des_in), .ip_start(ip_start),
    .ip_ready(ip_ready), .blk_done(blk_done), .blk_cnt(blk_cnt), .err(err)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // DES initial permutation, straight from the standard table.
  function automatic logic [63:0] ip_perm(input logic [63:0] x);
    int tab[64] = '{58,50,42,34,26,18,10,2, 60,52,44,36,28,20,12,4,
                    62,54,46,38,30,22,14,6, 64,56,48,40,32,24,16,8,
                    57,49,41,33,25,17, 9,1, 59,51,43,35,27,19,11,3,
                    61,53,45,37,29,21,13,5, 63,55,47,39,31,23,15,7};
    logic [63:0] r;
    r = '0;
    for (int i = 0; i < 64; i++) r[63-i] = x[64-tab[i]];
    return r;
  endfunction

  // IP stage model: raises ip_ready two edges after seeing ip_start, drops it
  // one edge after ip_start falls, and latches the permuted block.
  logic        ip_en;
  logic        stage1;
  logic [63:0] ip_out;
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stage1   <= 1'b0;
      ip_ready <= 1'b0;
      ip_out   <= '0;
    end else begin
      stage1   <= ip_en && ip_start;
      ip_ready <= ip_en && ip_start && stage1;
      if (ip_start && ip_ready) ip_out <= ip_perm(des_in);
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Send one byte (called just after a negedge); returns when it was accepted.
  task automatic send_byte(input logic [7:0] d, input logic fl, input int gap, output bit ok);
    int t;
    ok = 1'b0;
    repeat (gap) @(negedge clk);
    in_valid = 1'b1; in_data = d; flush = fl;
    t = 0;
    while (!in_ready && t < 50) begin
      @(negedge clk);
      t++;
    end
    if (in_ready) begin
      @(negedge clk);
      ok = 1'b1;
    end else begin
      n_checks++; n_fail++;
      $display("FAIL in_ready_wait: got in_ready=0 after %0d cycles expected 1", t);
    end
    in_valid = 1'b0; flush = 1'b0;
  endtask

  // Observe one handoff starting the cycle after byte 7 is accepted.
  task automatic handoff(input logic [63:0] exp, input logic [15:0] exp_cnt, input string tag);
    int st = 0, bd = 0, er = 0, irl = 0;
    logic [63:0] des_at_done = '0;
    for (int t = 0; t < 40 && !in_ready; t++) begin
      if (ip_start) st++;
      if (blk_done) begin bd++; des_at_done = des_in; end
      if (err) er++;
      irl++;
      @(negedge clk);
    end
    chk({tag, "_des"},        des_at_done, exp);
    chk({tag, "_ipstart"},    64'(st), 64'd3);
    chk({tag, "_blkdone"},    64'(bd), 64'd1);
    chk({tag, "_rdy_low"},    64'(irl), 64'd5);
    chk({tag, "_err"},        64'(er), 64'd0);
    chk({tag, "_blkcnt"},     64'(blk_cnt), 64'(exp_cnt));
    chk({tag, "_ipout"},      ip_out, ip_perm(exp));
  endtask

  typedef struct {
    int          n_junk;   // bytes sent before a flush cycle (0 = no flush)
    logic [63:0] blk;      // 8 bytes, first byte in bits 63:56
    int          gap;      // idle cycles before each byte
    logic [63:0] exp_des;
  } vec_t;

  initial begin
    vec_t        vecs[5];
    logic [63:0] cur;
    logic [63:0] mdl;
    int          mdl_n;
    logic [15:0] cnt;
    bit          ok;
    logic [7:0]  b;
    logic        fl;
    int          nblk;

    vecs[0] = '{0, 64'h0123456789ABCDEF, 0, 64'h0123456789ABCDEF};
    vecs[1] = '{3, 64'hFFFFFFFFFFFFFFFF, 0, 64'hFFFFFFFFFFFFFFFF};
    vecs[2] = '{0, 64'h1122334455667788, 1, 64'h1122334455667788};
    vecs[3] = '{0, 64'h99AABBCCDDEEFF00, 1, 64'h99AABBCCDDEEFF00};
    vecs[4] = '{5, 64'h0000000000000000, 0, 64'h0000000000000000};

    rst_n = 1'b0; in_valid = 1'b0; in_data = '0; flush = 1'b0; ip_en = 1'b1;
    repeat (2) @(negedge clk);
    chk("rst_in_ready", 64'(in_ready), 64'd0);
    chk("rst_des_in",   des_in, 64'd0);
    chk("rst_ip_start", 64'(ip_start), 64'd0);
    chk("rst_blk_done", 64'(blk_done), 64'd0);
    chk("rst_blk_cnt",  64'(blk_cnt), 64'd0);
    chk("rst_err",      64'(err), 64'd0);
    rst_n = 1'b1;
    chk("idle_in_ready", 64'(in_ready), 64'd0);
    @(negedge clk);
    chk("fill_in_ready", 64'(in_ready), 64'd1);

    cnt = '0;
    // Table-driven blocks
    for (int i = 0; i < 5; i++) begin
      for (int j = 0; j < vecs[i].n_junk; j++) send_byte(8'(8'hA0 + j), 1'b0, vecs[i].gap, ok);
      if (vecs[i].n_junk > 0) send_byte(8'h5A, 1'b1, vecs[i].gap, ok);
      cur = vecs[i].blk;
      for (int k = 0; k < 8; k++) send_byte(cur[63-8*k -: 8], 1'b0, vecs[i].gap, ok);
      cnt++;
      handoff(vecs[i].exp_des, cnt, $sformatf("vec%0d", i));
      if (i == 0) chk("vec0_ip_const", ip_out, 64'hCC00CCFFF0AAF0AA);
    end

    // Randomized byte stream with occasional flushes
    mdl = '0; mdl_n = 0; nblk = 0;
    for (int n = 0; n < 400 && nblk < 12; n++) begin
      b  = 8'($urandom);
      fl = ($urandom_range(0, 9) == 0);
      send_byte(b, fl, $urandom_range(0, 2), ok);
      if (ok && fl) mdl_n = 0;
      else if (ok) begin mdl = {mdl[55:0], b}; mdl_n++; end
      if (mdl_n == 8) begin
        cnt++; nblk++; mdl_n = 0;
        handoff(mdl, cnt, $sformatf("rnd%0d", nblk));
      end
    end
    chk("rnd_blocks", 64'(nblk), 64'd12);

    // IP stage silent: START either times out or waits forever
    ip_en = 1'b0;
    for (int k = 0; k < 8; k++) send_byte(8'(8'h10 + k), 1'b0, 0, ok);
    begin
      int st = 0, er = 0, bd = 0, first_err = -1;
      for (int t = 0; t < 100; t++) begin
        if (ip_start) st++;
        if (err) begin er++; if (first_err < 0) first_err = t; end
        if (blk_done) bd++;
        @(negedge clk);
      end
`ifdef DES_LOADER_TIMEOUT_EN
      chk("to_ipstart_cycles", 64'(st), 64'd4);
      chk("to_err_pulses",     64'(er), 64'd1);
      chk("to_err_pos",        64'(first_err), 64'd4);
`else
      chk("noto_ipstart_cycles", 64'(st), 64'd100);
      chk("noto_err_pulses",     64'(er), 64'd0);
`endif
      chk("silent_blkdone", 64'(bd), 64'd0);
      chk("silent_blkcnt",  64'(blk_cnt), 64'(cnt));
    end
`ifdef DES_LOADER_TIMEOUT_EN
    chk("to_back_to_fill", 64'(in_ready), 64'd1);
    for (int k = 0; k < 8; k++) send_byte(8'(8'h20 + k), 1'b0, 0, ok);
    repeat (2) @(negedge clk);
`endif
    chk("pre_rst_ip_start", 64'(ip_start), 64'd1);

    // Asynchronous reset while in START
    #1 rst_n = 1'b0;
    #1;
    chk("arst_ip_start", 64'(ip_start), 64'd0);
    chk("arst_des_in",   des_in, 64'd0);
    chk("arst_blk_cnt",  64'(blk_cnt), 64'd0);
    chk("arst_in_ready", 64'(in_ready), 64'd0);
    chk("arst_err",      64'(err), 64'd0);
    @(negedge clk);
    rst_n = 1'b1; ip_en = 1'b1; cnt = '0;
    @(negedge clk);
    chk("post_rst_in_ready", 64'(in_ready), 64'd1);
    cur = 64'hDEADBEEFCAFEF00D;
    for (int k = 0; k < 8; k++) send_byte(cur[63-8*k -: 8], 1'b0, 0, ok);
    cnt++;
    handoff(64'hDEADBEEFCAFEF00D, cnt, "post_rst");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/des_in_loader.md
# des_in_loader

Upstream feeder for the DES initial-permutation stage. Accepts plaintext as a byte stream over a valid/ready handshake and assembles eight bytes into a 64-bit block. Presents the block on `des_in[1:64]` and holds `ip_start` high until the IP stage returns `ip_ready`. Then releases the stage and signals block completion to the downstream sequencer.

## Interface
- `TIMEOUT_CYCLES`, default 15: maximum cycles in START waiting for `ip_ready`; used only with `DES_LOADER_TIMEOUT_EN`.
- `clk  input  1`: clock.
- `rst_n  input  1`: reset, asynchronous, active-low.
- `in_valid  input  1`: byte on `in_data` is valid.
- `in_data  input  8`: plaintext byte, first byte of a block first.
- `in_ready  output  1`: loader accepts a byte this cycle.
- `flush  input  1`: synchronous discard of a partially filled block.
- `des_in  output  [1:64]`: assembled block, bit 1 = MSB of first byte.
- `ip_start  output  1`: start request to the IP stage.
- `ip_ready  input  1`: IP stage completion flag.
- `blk_done  output  1`: one-cycle pulse, block handed off successfully.
- `blk_cnt  output  16`: count of completed blocks, wraps 0xFFFF→0.
- `err  output  1`: one-cycle pulse on timeout; constant 0 without the macro.

## Operation
- States: IDLE, FILL, START, RELEASE.
- Reset values:
  - state IDLE
  - `in_ready` 0, `des_in` 0, `ip_start` 0
  - `blk_done` 0, `blk_cnt` 0, `err` 0
  - byte counter 0
- IDLE → FILL on the first clock edge after reset release.
- `in_ready` = 1 only in FILL, decoded from the state register.
- Byte accept is `in_valid && in_ready`:
  - byte n (0..7) writes `des_in[8n+1:8n+8]`, with `in_data[7]` going to `des_in[8n+1]`.
  - Byte counter increments on each accept.
- Accept of byte 7 → START; byte counter returns to 0.
- START:
  - `ip_start` = 1; `des_in` frozen.
  - On sampling `ip_ready` = 1: `ip_start` ← 0, `blk_done` pulses, `blk_cnt` += 1, → RELEASE.
- RELEASE:
  - `ip_start` = 0, `in_ready` = 0.
  - On sampling `ip_ready` = 0 → FILL.
  - This prevents a stale `ip_ready` from completing the next block.
- `flush` in FILL: byte counter ← 0. `des_in` is not cleared; bytes already written are overwritten by later accepts.
- `flush` with `in_valid` in the same cycle: flush wins and the byte is dropped.
- `flush` in IDLE, START or RELEASE: ignored.
- `des_in` changes only on byte accepts in FILL, so it is stable whenever `ip_start` = 1.
- Reset mid-operation (any state): all outputs return to reset values immediately; the partial block is lost.

## Timing
- Byte accepts run at one byte per cycle with no bubbles inside FILL.
- Let edge k accept byte 7:
  - `ip_start` high from k.
  - The IP stage raises `ip_ready` after edge k+2.
  - The loader samples it at k+3: `ip_start` low and `blk_done` high during the cycle after k+3.
  - `ip_ready` falls after k+4.
  - The loader returns to FILL at k+5; `in_ready` is high after k+5.
- Block throughput with a standard IP stage is 8 accept cycles + 5 handoff cycles = 13 cycles per block.
- `blk_done` and `err` are registered pulses, exactly one cycle wide.

## Configuration
- `DES_LOADER_TIMEOUT_EN` defined:
  - A counter runs in START, cleared on START entry.
  - If `TIMEOUT_CYCLES` cycles elapse with `ip_ready` = 0: `ip_start` ← 0, `err` pulses, → RELEASE.
  - `blk_done` does not pulse and `blk_cnt` does not increment.
  - `ip_ready` sampled high on the same edge as expiry counts as success.
- Not defined:
  - START waits indefinitely.
  - No counter logic is synthesized; `err` is tied to 0.

## Test plan
- Reset, then bytes 0x01,0x23,0x45,0x67,0x89,0xAB,0xCD,0xEF back-to-back, with the IP stage model attached:
  - `des_in` = 0x0123456789ABCDEF.
  - `ip_start` high for 3 cycles.
  - `blk_done` one pulse; `blk_cnt` = 1.
  - IP output = 0xCC00CCFFF0AAF0AA.
- Send 3 bytes, assert `flush` together with a 4th byte, then send 8 bytes 0xFF:
  - `des_in` = 0xFFFFFFFFFFFFFFFF.
  - Exactly one `blk_done`.
- `in_valid` toggling every other cycle over 16 bytes:
  - Two blocks complete; `blk_cnt` = 2.
  - `in_ready` low for 5 cycles between blocks.
  - No byte lost or duplicated.
- `ip_ready` held low, with `DES_LOADER_TIMEOUT_EN` and `TIMEOUT_CYCLES` = 4:
  - `err` pulses after 4 START cycles.
  - `ip_start` drops; `blk_cnt` unchanged.
- The same stimulus without the macro: `ip_start` stays high for 100 cycles and `err` stays 0.
- Assert `rst_n` low while in START:
  - `ip_start`, `des_in` and `blk_cnt` go to 0 asynchronously.
  - After release, the next 8-byte block completes normally.
